// File: rtl/conv_job_sched_pkg.sv
// Shared types for the conv-layer job scheduler: job descriptor, error codes, FSM states.
package conv_sched_pkg;

    localparam int CHN_WIDTH = 10;
    localparam int FMS_WIDTH = 8;
    localparam int ID_WIDTH  = 4;

    typedef struct packed {
        logic [CHN_WIDTH-1:0] ci;
        logic [CHN_WIDTH-1:0] co;
        logic                 stride;
        logic [FMS_WIDTH-1:0] ifm_size;
        logic [ID_WIDTH-1:0]  id;
    } job_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_CFG     = 2'b10,
        ERR_ABORT   = 2'b11
    } err_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        KRST,
        DONE
    } state_e;

endpackage

// File: rtl/conv_job_sched_if.sv
// Host-side job/completion handshake plus the conv2d_3x3 control/config bundle.
interface conv_job_sched_if #(
    parameter int CYC_WIDTH = 32
);
    import conv_sched_pkg::*;

    logic                 job_valid;
    logic                 job_ready;
    logic [CHN_WIDTH-1:0] job_ci;
    logic [CHN_WIDTH-1:0] job_co;
    logic                 job_stride;
    logic [FMS_WIDTH-1:0] job_ifm_size;
    logic [ID_WIDTH-1:0]  job_id;
    logic                 abort;

    logic [CHN_WIDTH-1:0] cfg_ci;
    logic [CHN_WIDTH-1:0] cfg_co;
    logic                 cfg_stride;
    logic [FMS_WIDTH-1:0] cfg_ifm_size;
    logic                 start_conv;
    logic                 kern_rstn;
    logic                 conv_done;
    logic                 ifm_read;
    logic                 wgt_read;

    logic                 busy;
    logic                 done_valid;
    logic [ID_WIDTH-1:0]  done_id;
    logic [1:0]           done_err;
    logic [CYC_WIDTH-1:0] done_cycles;

    modport slave (
        input  job_valid, job_ci, job_co, job_stride, job_ifm_size, job_id, abort,
        input  conv_done, ifm_read, wgt_read,
        output job_ready, cfg_ci, cfg_co, cfg_stride, cfg_ifm_size, start_conv, kern_rstn,
        output busy, done_valid, done_id, done_err, done_cycles
    );

    modport master (
        output job_valid, job_ci, job_co, job_stride, job_ifm_size, job_id, abort,
        output conv_done, ifm_read, wgt_read,
        input  job_ready, cfg_ci, cfg_co, cfg_stride, cfg_ifm_size, start_conv, kern_rstn,
        input  busy, done_valid, done_id, done_err, done_cycles
    );

endinterface

// File: rtl/conv_job_sched_fifo.sv
// Synchronous job-descriptor queue; pushes while full and pops while empty are dropped.
module sched_job_fifo
    import conv_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  job_t wr_data,
    output job_t rd_data,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    job_t          mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/conv_job_sched.sv
// Runs queued conv jobs one at a time on conv2d_3x3, with watchdog, abort and cycle accounting.
module conv_job_sched
    import conv_sched_pkg::*;
#(
    parameter int                   FIFO_DEPTH = 4,
    parameter int                   WDT_WIDTH  = 16,
    parameter logic [WDT_WIDTH-1:0] WDT_LIMIT  = 16'hFFFF,
    parameter int                   CYC_WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst,
    conv_job_sched_if.slave  bus
);
    localparam logic [WDT_WIDTH-1:0] WDT_LAST = WDT_LIMIT - 1'b1;

    state_e                state_q, state_d;
    job_t                  cfg_q, cfg_d;
    err_e                  err_q, err_d;
    logic [WDT_WIDTH-1:0]  wdt_q, wdt_d;
    logic [CYC_WIDTH-1:0]  cyc_q, cyc_d;
    logic                  krst_q, krst_d;
    logic                  conv_done_q, conv_done_d;

    job_t                  fifo_wr, fifo_rd;
    logic                  fifo_full, fifo_empty, pop;
    logic                  done_rise, kick;

    function automatic logic [CYC_WIDTH-1:0] sat_inc(input logic [CYC_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign fifo_wr = '{ci: bus.job_ci, co: bus.job_co, stride: bus.job_stride,
                       ifm_size: bus.job_ifm_size, id: bus.job_id};

    sched_job_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.job_valid),
        .pop     (pop),
        .wr_data (fifo_wr),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A done level carried over from the previous job never produces a rise.
    assign conv_done_d = bus.conv_done;
    assign done_rise   = bus.conv_done & ~conv_done_q;
    assign kick        = bus.ifm_read | bus.wgt_read;

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        err_d   = err_q;
        wdt_d   = wdt_q;
        cyc_d   = cyc_q;
        krst_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cfg_d   = fifo_rd;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cyc_d = '0;
                if (cfg_q.ci == '0 || cfg_q.co == '0 || cfg_q.ifm_size < FMS_WIDTH'(3)) begin
                    err_d   = ERR_CFG;
                    state_d = DONE;
                end else begin
                    state_d = START;
                end
            end
            START: begin
                wdt_d   = '0;
                cyc_d   = '0;
                err_d   = ERR_OK;
                state_d = RUN;
            end
            RUN: begin
                cyc_d = sat_inc(cyc_q);
                if (bus.abort) begin
                    err_d   = ERR_ABORT;
                    state_d = KRST;
                end else if (done_rise) begin
                    err_d   = ERR_OK;
                    state_d = DONE;
                end else if (kick) begin
                    wdt_d = '0;
                end else if (wdt_q == WDT_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = KRST;
                end else begin
                    wdt_d = wdt_q + 1'b1;
                end
            end
            KRST: begin
                cyc_d  = sat_inc(cyc_q);
                krst_d = ~krst_q;
                if (krst_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            err_q       <= ERR_OK;
            wdt_q       <= '0;
            cyc_q       <= '0;
            krst_q      <= 1'b0;
            conv_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            err_q       <= err_d;
            wdt_q       <= wdt_d;
            cyc_q       <= cyc_d;
            krst_q      <= krst_d;
            conv_done_q <= conv_done_d;
        end
    end

    assign bus.job_ready    = ~fifo_full;
    assign bus.cfg_ci       = cfg_q.ci;
    assign bus.cfg_co       = cfg_q.co;
    assign bus.cfg_stride   = cfg_q.stride;
    assign bus.cfg_ifm_size = cfg_q.ifm_size;
    assign bus.start_conv   = (state_q == START);
    assign bus.kern_rstn    = (state_q != KRST);
    assign bus.busy         = (state_q != IDLE) | ~fifo_empty;
    assign bus.done_valid   = (state_q == DONE);
    assign bus.done_id      = cfg_q.id;
    assign bus.done_err     = err_q;
    assign bus.done_cycles  = cyc_q;

endmodule

// File: tb/tb_conv_job_sched.sv
// Directed bench for conv_job_sched: latency, queueing, bad cfg, watchdog, abort, stale done, reset.
module tb_conv_job_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   s_at, r_at, nstart, ndone, n;

    conv_job_sched_if #(.CYC_WIDTH(32)) bus ();

    conv_job_sched #(
        .FIFO_DEPTH (4),
        .WDT_WIDTH  (16),
        .WDT_LIMIT  (16'd16),
        .CYC_WIDTH  (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_job(input logic [9:0] ci, input logic [9:0] co, input logic s,
                            input logic [7:0] sz, input logic [3:0] id);
        bus.job_valid    = 1'b1;
        bus.job_ci       = ci;
        bus.job_co       = co;
        bus.job_stride   = s;
        bus.job_ifm_size = sz;
        bus.job_id       = id;
        tick();
        bus.job_valid    = 1'b0;
    endtask

    task automatic wait_start(input string tag, output int at);
        int k;
        k = 0;
        while (bus.start_conv !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk(tag, bus.start_conv, 1'b1);
        at = cyc;
    endtask

    initial begin
        bus.job_valid = 0; bus.job_ci = 0; bus.job_co = 0; bus.job_stride = 0;
        bus.job_ifm_size = 0; bus.job_id = 0; bus.abort = 0;
        bus.conv_done = 0; bus.ifm_read = 0; bus.wgt_read = 0;

        // Reset values
        tick(); tick();
        chk("rst_ready", bus.job_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_start", bus.start_conv, 1'b0);
        chk("rst_kern_rstn", bus.kern_rstn, 1'b1);
        chk("rst_done_valid", bus.done_valid, 1'b0);
        chk("rst_cfg_ci", bus.cfg_ci, 10'd0);
        chk("rst_done_cycles", bus.done_cycles, 32'd0);
        rst = 1'b0;
        tick();

        // 1: single job, start 3 cycles after push, done 200 cycles after start
        bus.ifm_read = 1'b1;
        push_job(10'd64, 10'd64, 1'b0, 8'd16, 4'd3);
        chk("t1_start_p1", bus.start_conv, 1'b0);
        tick();
        chk("t1_start_p2", bus.start_conv, 1'b0);
        chk("t1_cfg_ci_load", bus.cfg_ci, 10'd64);
        tick();
        chk("t1_start_p3", bus.start_conv, 1'b1);
        chk("t1_cfg_size", bus.cfg_ifm_size, 8'd16);
        nstart = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.start_conv === 1'b1) nstart++;
        end
        bus.conv_done = 1'b1;
        chk("t1_busy_run", bus.busy, 1'b1);
        tick();
        bus.conv_done = 1'b0;
        chk("t1_nstart", nstart, 1);
        chk("t1_done_valid", bus.done_valid, 1'b1);
        chk("t1_done_id", bus.done_id, 4'd3);
        chk("t1_done_err", bus.done_err, 2'b00);
        chk("t1_done_cycles", bus.done_cycles, 32'd200);
        tick();
        chk("t1_done_pulse", bus.done_valid, 1'b0);
        chk("t1_idle_busy", bus.busy, 1'b0);
        chk("t1_cfg_hold", bus.cfg_co, 10'd64);

        // 2: five jobs back-to-back; queue fills, ids in order, 4-cycle gap
        nstart = 0;
        s_at = 0;
        bus.job_valid = 1'b1;
        bus.job_ci = 10'd8; bus.job_co = 10'd16; bus.job_stride = 1'b1; bus.job_ifm_size = 8'd8;
        for (int k = 0; k < 5; k++) begin
            bus.job_id = 4'(k + 1);
            tick();
            if (bus.start_conv === 1'b1) begin nstart++; s_at = cyc; end
        end
        chk("t2_first_start", nstart, 1);
        chk("t2_full", bus.job_ready, 1'b0);
        bus.job_id = 4'd15;
        tick();
        bus.job_valid = 1'b0;
        chk("t2_full_hold", bus.job_ready, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) begin
                wait_start("t2_start_seen", s_at);
                chk("t2_gap", s_at - r_at, 4);
            end
            n = 0;
            while (cyc < s_at + 5 && n < 10) begin tick(); n++; end
            bus.conv_done = 1'b1;
            r_at = cyc;
            tick();
            bus.conv_done = 1'b0;
            chk("t2_done_valid", bus.done_valid, 1'b1);
            chk("t2_done_id", bus.done_id, 4'(k));
            chk("t2_done_cycles", bus.done_cycles, 32'd5);
        end
        tick();
        chk("t2_drained", bus.busy, 1'b0);
        chk("t2_ready", bus.job_ready, 1'b1);

        // 3: ci=0 -> no start, err=10
        push_job(10'd0, 10'd16, 1'b0, 8'd8, 4'd7);
        chk("t3_start_a", bus.start_conv, 1'b0);
        tick();
        chk("t3_start_b", bus.start_conv, 1'b0);
        tick();
        chk("t3_start_c", bus.start_conv, 1'b0);
        chk("t3_done_valid", bus.done_valid, 1'b1);
        chk("t3_done_err", bus.done_err, 2'b10);
        chk("t3_done_id", bus.done_id, 4'd7);
        chk("t3_done_cycles", bus.done_cycles, 32'd0);
        tick();

        // 4: watchdog timeout with WDT_LIMIT=16
        bus.ifm_read = 1'b0;
        push_job(10'd16, 10'd16, 1'b0, 8'd8, 4'd9);
        wait_start("t4_start_seen", s_at);
        for (int i = 0; i < 16; i++) tick();
        chk("t4_kern_pre", bus.kern_rstn, 1'b1);
        chk("t4_no_done_pre", bus.done_valid, 1'b0);
        tick();
        chk("t4_kern_low1", bus.kern_rstn, 1'b0);
        tick();
        chk("t4_kern_low2", bus.kern_rstn, 1'b0);
        tick();
        chk("t4_done_at_19", cyc - s_at, 19);
        chk("t4_done_valid", bus.done_valid, 1'b1);
        chk("t4_done_err", bus.done_err, 2'b01);
        chk("t4_done_id", bus.done_id, 4'd9);
        chk("t4_kern_back", bus.kern_rstn, 1'b1);
        tick();

        // 5: abort and done rise together -> aborted
        bus.ifm_read = 1'b1;
        push_job(10'd32, 10'd32, 1'b1, 8'd10, 4'd5);
        wait_start("t5_start_seen", s_at);
        tick(); tick(); tick();
        bus.abort = 1'b1;
        bus.conv_done = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t5_no_done", bus.done_valid, 1'b0);
        chk("t5_kern_low1", bus.kern_rstn, 1'b0);
        tick();
        chk("t5_kern_low2", bus.kern_rstn, 1'b0);
        tick();
        chk("t5_done_valid", bus.done_valid, 1'b1);
        chk("t5_done_err", bus.done_err, 2'b11);
        chk("t5_done_id", bus.done_id, 4'd5);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t5_idle_abort_ignored", bus.kern_rstn, 1'b1);

        // 6a: conv_done still high into START -> only a fresh rise completes
        push_job(10'd4, 10'd4, 1'b0, 8'd3, 4'd6);
        wait_start("t6_start_seen", s_at);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done_valid === 1'b1) ndone++;
        end
        chk("t6_no_early_done", ndone, 0);
        bus.conv_done = 1'b0;
        tick();
        bus.conv_done = 1'b1;
        tick();
        bus.conv_done = 1'b0;
        chk("t6_done_valid", bus.done_valid, 1'b1);
        chk("t6_done_id", bus.done_id, 4'd6);
        chk("t6_done_err", bus.done_err, 2'b00);
        chk("t6_done_cycles", bus.done_cycles, 32'd11);
        tick();

        // 6b: reset mid-RUN drops the job
        push_job(10'd8, 10'd8, 1'b0, 8'd8, 4'd2);
        wait_start("t6b_start_seen", s_at);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("t6b_busy", bus.busy, 1'b0);
        chk("t6b_ready", bus.job_ready, 1'b1);
        chk("t6b_kern_rstn", bus.kern_rstn, 1'b1);
        chk("t6b_cfg_ci", bus.cfg_ci, 10'd0);
        chk("t6b_done_cycles", bus.done_cycles, 32'd0);
        tick();
        rst = 1'b0;
        ndone = 0;
        nstart = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done_valid === 1'b1) ndone++;
            if (bus.start_conv === 1'b1) nstart++;
        end
        chk("t6b_no_done", ndone, 0);
        chk("t6b_no_start", nstart, 0);
        chk("t6b_idle", bus.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
